// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions N_BTN raw, asynchronous push-button inputs into clean,
// cycle-accurate events. Each channel is fully independent:
//
//   btn_in -> synchronizer -> debouncer -> edge pulses -> auto-repeat -> events
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rst         asynchronous reset, active low; clears every flop
//   btn_in      raw button levels, 1 = pressed
//   rep_en      per-channel auto-repeat enable
//   evt_clr     per-channel clear of the sticky event flag
//   level       debounced button level
//   press       one-cycle pulse in the first cycle level reads 1
//   rls         one-cycle pulse in the first cycle level reads 0
//               (the natural name "release" is a reserved word)
//   stroke      one-cycle pulse on press and on every auto-repeat
//   evt         sticky flag, set by stroke, cleared by evt_clr
//   any_stroke  OR of all stroke bits
//
// Latency: a stable input change becomes visible on level (and press/rls)
// SYNC_STAGES + DEB_CYC rising edges after the first edge that samples it.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_BTN       = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 4,
  parameter int REP_DELAY   = 10,
  parameter int REP_RATE    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] rep_en,
  input  logic [N_BTN-1:0] evt_clr,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rls,
  output logic [N_BTN-1:0] stroke,
  output logic [N_BTN-1:0] evt,
  output logic             any_stroke
);

  // Debounce counter only ever holds 0..DEB_CYC-1; it is cleared on the
  // edge where it would reach DEB_CYC, so it never wraps.
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  // Repeat counter is sized for the larger of its two reload values.
  localparam int REP_MAX = ((REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE) - 1;
  localparam int REP_W   = (REP_MAX < 1) ? 1 : $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY_LD  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RATE_LD = REP_W'(REP_RATE - 1);

  // Auto-repeat state machine encoding
  localparam logic [1:0] ST_IDLE  = 2'b00;  // debounced level is 0
  localparam logic [1:0] ST_DELAY = 2'b01;  // waiting for the first repeat
  localparam logic [1:0] ST_RATE  = 2'b10;  // repeating at REP_RATE

  genvar i;
  generate
    for (i = 0; i < N_BTN; i++) begin : g_chan

      logic [SYNC_STAGES-1:0] sync_q;
      logic [DEB_W-1:0]       deb_cnt;
      logic                   lvl_q;
      logic [1:0]             rep_st;
      logic [REP_W-1:0]       rep_cnt;
      logic                   press_q;
      logic                   rls_q;
      logic                   stroke_q;
      logic                   evt_q;

      logic sync_out;
      logic differ;
      logic deb_done;
      logic rise;
      logic fall;
      logic rep_fire;

      // ---- synchronizer stage ----------------------------------------------
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
        end
      end

      assign sync_out = sync_q[SYNC_STAGES-1];

      // ---- debounce stage --------------------------------------------------
      // Count consecutive edges where the synchronized input disagrees with
      // the debounced level; any agreement restarts the count, so a glitch
      // shorter than DEB_CYC cycles never reaches level.
      assign differ   = sync_out ^ lvl_q;
      assign deb_done = differ && (deb_cnt == DEB_LAST);
      assign rise     = deb_done & ~lvl_q;
      assign fall     = deb_done &  lvl_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          deb_cnt <= '0;
          lvl_q   <= 1'b0;
        end else begin
          if (!differ || deb_done) begin
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
          lvl_q <= lvl_q ^ deb_done;
        end
      end

      // ---- auto-repeat stage -----------------------------------------------
      // A repeat fires on the edge that finds the counter at 0 while the
      // channel is active and enabled. A release on the same edge wins, and
      // rep_en=0 freezes the counter so repeats resume from where they were.
      assign rep_fire = (rep_st != ST_IDLE) && rep_en[i] &&
                        (rep_cnt == '0) && !fall;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rep_st  <= ST_IDLE;
          rep_cnt <= '0;
        end else if (fall) begin
          rep_st  <= ST_IDLE;
          rep_cnt <= '0;
        end else begin
          case (rep_st)
            ST_IDLE: begin
              if (rise) begin
                rep_st  <= ST_DELAY;
                rep_cnt <= REP_DLY_LD;
              end
            end
            ST_DELAY, ST_RATE: begin
              if (rep_en[i]) begin
                if (rep_cnt == '0) begin
                  rep_st  <= ST_RATE;
                  rep_cnt <= REP_RATE_LD;
                end else begin
                  rep_cnt <= rep_cnt - 1'b1;
                end
              end
            end
            default: begin
              rep_st  <= ST_IDLE;
              rep_cnt <= '0;
            end
          endcase
        end
      end

      // ---- event output stage ----------------------------------------------
      // press/rls/stroke are registered so they line up with the new level.
      // evt is set from the registered stroke, so a clear arriving in the
      // stroke cycle cannot beat the set.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          press_q  <= 1'b0;
          rls_q    <= 1'b0;
          stroke_q <= 1'b0;
          evt_q    <= 1'b0;
        end else begin
          press_q  <= rise;
          rls_q    <= fall;
          stroke_q <= rise | rep_fire;
          evt_q    <= stroke_q | (evt_q & ~evt_clr[i]);
        end
      end

      assign level[i]  = lvl_q;
      assign press[i]  = press_q;
      assign rls[i]    = rls_q;
      assign stroke[i] = stroke_q;
      assign evt[i]    = evt_q;

    end
  endgenerate

  assign any_stroke = |stroke;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner at default parameters. A table of
// per-cycle vectors covers press/release, glitch rejection, sticky events and
// simultaneous channels; hand-written sequences cover auto-repeat timing,
// repeat hold via rep_en, and asynchronous reset in the middle of a repeat.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn_in  = '0;
  logic [4:0] rep_en  = '0;
  logic [4:0] evt_clr = '0;
  logic [4:0] level, press, rls, stroke, evt;
  logic       any_stroke;

  int ntests = 0;
  int nfail  = 0;

  button_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .rep_en     (rep_en),
    .evt_clr    (evt_clr),
    .level      (level),
    .press      (press),
    .rls        (rls),
    .stroke     (stroke),
    .evt        (evt),
    .any_stroke (any_stroke)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  btn;
    logic [4:0]  clr;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [25:0] obs();
    return {level, press, rls, stroke, evt, any_stroke};
  endfunction

  task automatic add(input logic [4:0] b, input logic [4:0] c,
                     input logic [4:0] l, input logic [4:0] p,
                     input logic [4:0] r, input logic [4:0] s,
                     input logic [4:0] e, input logic a);
    vec_t v;
    v.btn = b;
    v.clr = c;
    v.exp = {l, p, r, s, e, a};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rep_pat(input int k, input int first);
    return (k == first) || ((k > first) && (((k - first) % 3) == 0));
  endfunction

  initial begin
    // ch0: press, sticky evt, clear, release
    repeat (5) add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
    add(5'h01, 5'h00, 5'h01, 5'h01, 5'h00, 5'h01, 5'h00, 1'b1);
    add(5'h01, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00, 5'h01, 1'b0);
    add(5'h01, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00, 5'h01, 1'b0);
    add(5'h01, 5'h01, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
    add(5'h01, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
    repeat (5) add(5'h00, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
    add(5'h00, 5'h00, 5'h00, 5'h00, 5'h01, 5'h00, 5'h00, 1'b0);
    add(5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
    // ch1: 3-cycle glitch is ignored
    repeat (3) add(5'h02, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
    repeat (7) add(5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
    // ch0: evt_clr in the stroke cycle does not win
    repeat (5) add(5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
    add(5'h01, 5'h00, 5'h01, 5'h01, 5'h00, 5'h01, 5'h00, 1'b1);
    add(5'h01, 5'h01, 5'h01, 5'h00, 5'h00, 5'h00, 5'h01, 1'b0);
    add(5'h01, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00, 5'h01, 1'b0);
    repeat (5) add(5'h00, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00, 5'h01, 1'b0);
    add(5'h00, 5'h00, 5'h00, 5'h00, 5'h01, 5'h00, 5'h01, 1'b0);
    add(5'h00, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
    // ch3+ch4 together; no repeats with rep_en=0
    repeat (5) add(5'h18, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
    add(5'h18, 5'h00, 5'h18, 5'h18, 5'h00, 5'h18, 5'h00, 1'b1);
    repeat (12) add(5'h18, 5'h00, 5'h18, 5'h00, 5'h00, 5'h00, 5'h18, 1'b0);
    repeat (5) add(5'h00, 5'h00, 5'h18, 5'h00, 5'h00, 5'h00, 5'h18, 1'b0);
    add(5'h00, 5'h00, 5'h00, 5'h00, 5'h18, 5'h00, 5'h18, 1'b0);
    add(5'h00, 5'h1f, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);

    // Reset state while rst is low
    #12;
    check("reset_state", 32'(obs()), 32'h0);
    #11;
    rst = 1'b1;
    tick();

    foreach (tbl[n]) begin
      btn_in  = tbl[n].btn;
      evt_clr = tbl[n].clr;
      tick();
      check($sformatf("row%0d", n), 32'(obs()), 32'(tbl[n].exp));
    end
    btn_in  = '0;
    evt_clr = '0;

    // ch2 auto-repeat: strokes at P, P+10, P+13, ...; release stops them
    rep_en = 5'h04;
    btn_in = 5'h04;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("rep_press%0d", k), {30'h0, press[2], stroke[2]},
            (k == 6) ? 32'h3 : 32'h0);
    end
    for (int k = 1; k <= 45; k++) begin
      if (k == 31) btn_in = 5'h00;
      tick();
      check($sformatf("rep_k%0d", k), {30'h0, stroke[2], rls[2]},
            {30'h0, (k < 36) && rep_pat(k, 10), (k == 36)});
    end
    check("rep_evt", {31'h0, evt[2]}, 32'h1);
    evt_clr = 5'h04;
    tick();
    evt_clr = 5'h00;
    check("rep_evt_clr", {27'h0, evt}, 32'h0);

    // ch2 repeat hold: rep_en low for 4 edges delays repeats by 4
    btn_in = 5'h04;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("hold_press%0d", k), {31'h0, press[2]},
            (k == 6) ? 32'h1 : 32'h0);
    end
    for (int k = 1; k <= 22; k++) begin
      if (k == 5) rep_en = 5'h00;
      if (k == 9) rep_en = 5'h04;
      tick();
      check($sformatf("hold_k%0d", k), {31'h0, stroke[2]},
            {31'h0, rep_pat(k, 14)});
    end

    // Asynchronous reset mid-repeat with the button still held
    check("pre_rst_level", {31'h0, level[2]}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", 32'(obs()), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold", 32'(obs()), 32'h0);
    #3;
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("rst_exit%0d", k), {29'h0, level[2], press[2], stroke[2]},
            (k == 6) ? 32'h7 : 32'h0);
    end
    tick();
    check("rst_after", {29'h0, level[2], press[2], evt[2]}, 32'h5);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
